shift_arbiter: RTL and testbench

Shares one 32-bit barrel shifter (the existing `SHIFTER` block) between `NUM_REQ` requesters, such as the execute path and a multi-cycle helper unit.
- Arbitration is round-robin.
- Operands are registered, the shift runs in one cycle, and the result is held until the owning requester accepts it.
- The block sits beside the ALU in the datapath and has no knowledge of instructions.

---
 rtl/shift_pkg.sv | 27 ++
 rtl/SHIFTER.sv | 28 ++
 rtl/shift_arbiter.sv | 122 ++++++++++++
 tb/tb_shift_arbiter.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// Shared types and widths for the shift arbiter: FSM states, operand widths
// and the shifter operation select.
package shift_pkg;

  localparam int DATA_W = 32;
  localparam int SA_W   = 5;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    RESP
  } state_e;

  typedef enum logic [1:0] {
    LEFT,
    RIGHT_LOGICAL,
    RIGHT_ARITH
  } op_e;

  // A left shift never sign-fills, so arith only matters when right is set.
  function automatic op_e op_sel(input logic right, input logic arith);
    if (!right)     return LEFT;
    else if (arith) return RIGHT_ARITH;
    else            return RIGHT_LOGICAL;
  endfunction

endpackage

// File: rtl/SHIFTER.sv
// Existing 32-bit single-cycle barrel shifter: left, logical right or
// arithmetic right by 0..31.
module SHIFTER
  import shift_pkg::*;
(
  input  logic [DATA_W-1:0] Data,
  input  logic [SA_W-1:0]   Sa,
  input  logic              Right,
  input  logic              Arith,
  output logic [DATA_W-1:0] Result
);

  op_e op;

  // NOTE: every signal assigned in always_comb gets a value on every path
  // (default first), otherwise synthesis infers a latch.
  always_comb begin
    Result = Data;
    op     = op_sel(Right, Arith);
    case (op)
      LEFT:          Result = Data << Sa;
      RIGHT_LOGICAL: Result = Data >> Sa;
      RIGHT_ARITH:   Result = $unsigned($signed(Data) >>> Sa);
      default:       Result = Data;
    endcase
  end

endmodule

// File: rtl/shift_arbiter.sv
// Round-robin arbiter sharing one SHIFTER between NUM_REQ requesters; operands
// are registered, shifted in one cycle and the result held until accepted.
module shift_arbiter
  import shift_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ*SA_W-1:0]   req_sa,
  input  logic [NUM_REQ-1:0]        req_right,
  input  logic [NUM_REQ-1:0]        req_arith,
  output logic [NUM_REQ-1:0]        rsp_valid,
  input  logic [NUM_REQ-1:0]        rsp_ready,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      busy
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_e             state;
  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   owner;
  logic [IDX_W-1:0]   winner;
  logic [IDX_W-1:0]   next_ptr;
  logic               any_valid;
  logic [DATA_W-1:0]  op_data;
  logic [SA_W-1:0]    op_sa;
  logic               op_right;
  logic               op_arith;
  logic [DATA_W-1:0]  shift_out;
  logic [DATA_W-1:0]  data_arr [NUM_REQ];
  logic [SA_W-1:0]    sa_arr   [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign data_arr[g] = req_data[g*DATA_W +: DATA_W];
    assign sa_arr[g]   = req_sa[g*SA_W +: SA_W];
  end

  // First valid requester at or after ptr, wrapping modulo NUM_REQ.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                               input logic [IDX_W-1:0]   ptr);
    logic found;
    int   idx;
    rr_pick = ptr;
    found   = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(ptr) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && valid[IDX_W'(idx)]) begin
        found   = 1'b1;
        rr_pick = IDX_W'(idx);
      end
    end
  endfunction

  always_comb begin
    winner    = rr_pick(req_valid, rr_ptr);
    any_valid = |req_valid;
    next_ptr  = (owner == IDX_W'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
    req_ready = '0;
    // Grant is gated by rst so no handshake can be seen while reset is held.
    if (state == IDLE && !rst && any_valid) req_ready[winner] = 1'b1;
  end

  SHIFTER u_shifter (
    .Data   (op_data),
    .Sa     (op_sa),
    .Right  (op_right),
    .Arith  (op_arith),
    .Result (shift_out)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      owner     <= '0;
      rsp_data  <= '0;
      rsp_valid <= '0;
      busy      <= 1'b0;
      op_data   <= '0;
      op_sa     <= '0;
      op_right  <= 1'b0;
      op_arith  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_valid) begin
            owner    <= winner;
            op_data  <= data_arr[winner];
            op_sa    <= sa_arr[winner];
            op_right <= req_right[winner];
            op_arith <= req_arith[winner];
            busy     <= 1'b1;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          rsp_data         <= shift_out;
          rsp_valid[owner] <= 1'b1;
          state            <= RESP;
        end
        RESP: begin
          if (rsp_ready[owner]) begin
            rr_ptr    <= next_ptr;
            rsp_valid <= '0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_arbiter.sv
// Directed bench for shift_arbiter (NUM_REQ = 2): shift modes, round-robin
// fairness, response stall and asynchronous reset in SHIFT and RESP.
module tb_shift_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [63:0] req_data;
  logic [9:0]  req_sa;
  logic [1:0]  req_right;
  logic [1:0]  req_arith;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready;
  logic [31:0] rsp_data;
  logic        busy;

  logic [31:0] data_a [2];
  logic [4:0]  sa_a   [2];

  int n_checks = 0;
  int n_fail   = 0;

  assign req_data = {data_a[1], data_a[0]};
  assign req_sa   = {sa_a[1], sa_a[0]};

  always #5 clk = ~clk;

  shift_arbiter #(.NUM_REQ(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_data  (req_data),
    .req_sa    (req_sa),
    .req_right (req_right),
    .req_arith (req_arith),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One complete operation from IDLE with only port p requesting.
  task automatic run_op(input logic p, input logic [31:0] d, input logic [4:0] sa,
                        input logic r, input logic a, input logic [31:0] exp,
                        input string tag);
    data_a[p]    = d;
    sa_a[p]      = sa;
    req_right[p] = r;
    req_arith[p] = a;
    req_valid    = 2'b01 << p;
    rsp_ready    = 2'b00;
    #1;
    check({tag, "_grant"}, 32'(req_ready), 32'(2'b01 << p));
    @(posedge clk); #1;
    req_valid = 2'b00;
    check({tag, "_busy"}, 32'(busy), 32'd1);
    check({tag, "_shift_ready"}, 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'(2'b01 << p));
    check({tag, "_rsp_data"}, rsp_data, exp);
    rsp_ready = 2'b01 << p;
    @(posedge clk); #1;
    rsp_ready = 2'b00;
    check({tag, "_done_valid"}, 32'(rsp_valid), 32'd0);
    check({tag, "_done_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    logic p;
    rst       = 1'b1;
    req_valid = 2'b00;
    req_right = 2'b00;
    req_arith = 2'b00;
    rsp_ready = 2'b00;
    data_a[0] = '0; data_a[1] = '0;
    sa_a[0]   = '0; sa_a[1]   = '0;

    @(posedge clk); #1;
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_valid", 32'(rsp_valid), 32'd0);
    check("rst_data", rsp_data, 32'h0);
    check("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;

    // Shift modes on port 0.
    run_op(1'b0, 32'h8000_0000, 5'd4, 1'b1, 1'b1, 32'hF800_0000, "asr");
    run_op(1'b0, 32'h8000_0000, 5'd4, 1'b1, 1'b0, 32'h0800_0000, "lsr");
    run_op(1'b0, 32'h0000_0001, 5'd31, 1'b0, 1'b1, 32'h8000_0000, "lsl31");

    // Asynchronous reset while in RESP, with a new request pending.
    data_a[0] = 32'h0000_000F; sa_a[0] = 5'd1; req_right[0] = 1'b0;
    req_valid = 2'b01;
    @(posedge clk); #1;
    req_valid = 2'b00;
    @(posedge clk); #1;
    check("arst_pre_valid", 32'(rsp_valid), 32'd1);
    check("arst_pre_data", rsp_data, 32'h0000_001E);
    req_valid = 2'b01;
    #2;
    rst = 1'b1;
    #1;
    check("arst_ready", 32'(req_ready), 32'd0);
    check("arst_valid", 32'(rsp_valid), 32'd0);
    check("arst_data", rsp_data, 32'h0);
    check("arst_busy", 32'(busy), 32'd0);
    req_valid = 2'b00;
    #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Fairness: both ports request continuously, both always accept.
    data_a[0] = 32'h0000_00F0; sa_a[0] = 5'd4; req_right[0] = 1'b0; req_arith[0] = 1'b0;
    data_a[1] = 32'hF000_0000; sa_a[1] = 5'd4; req_right[1] = 1'b1; req_arith[1] = 1'b1;
    req_valid = 2'b11;
    rsp_ready = 2'b11;
    #1;
    for (int i = 0; i < 6; i++) begin
      p = i[0];
      check($sformatf("fair%0d_grant", i), 32'(req_ready), 32'(2'b01 << p));
      check($sformatf("fair%0d_onehot", i), 32'($onehot(req_ready)), 32'd1);
      @(posedge clk); #1;
      @(posedge clk); #1;
      check($sformatf("fair%0d_rsp_valid", i), 32'(rsp_valid), 32'(2'b01 << p));
      check($sformatf("fair%0d_rsp_data", i), rsp_data, p ? 32'hFF00_0000 : 32'h0000_0F00);
      @(posedge clk); #1;
    end
    req_valid = 2'b00;
    rsp_ready = 2'b00;

    // Response stall on port 1 while port 0 waits.
    data_a[1] = 32'h1234_5678; sa_a[1] = 5'd8; req_right[1] = 1'b1; req_arith[1] = 1'b0;
    req_valid = 2'b10;
    #1;
    check("stall_grant1", 32'(req_ready), 32'd2);
    @(posedge clk); #1;
    data_a[0] = 32'h0000_0003; sa_a[0] = 5'd2; req_right[0] = 1'b0;
    req_valid = 2'b01;
    rsp_ready = 2'b01;
    #1;
    check("stall_shift_ready", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    for (int k = 0; k < 5; k++) begin
      check($sformatf("stall%0d_valid", k), 32'(rsp_valid), 32'd2);
      check($sformatf("stall%0d_data", k), rsp_data, 32'h0012_3456);
      check($sformatf("stall%0d_ready", k), 32'(req_ready), 32'd0);
      @(posedge clk); #1;
    end
    rsp_ready = 2'b10;
    @(posedge clk); #1;
    rsp_ready = 2'b00;
    check("stall_after_valid", 32'(rsp_valid), 32'd0);
    check("stall_grant0", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 2'b00;
    @(posedge clk); #1;
    check("stall_p0_valid", 32'(rsp_valid), 32'd1);
    check("stall_p0_data", rsp_data, 32'h0000_000C);
    rsp_ready = 2'b01;
    @(posedge clk); #1;
    rsp_ready = 2'b00;

    // Reset during SHIFT: the operation must vanish without a response.
    data_a[0] = 32'h0000_0055; sa_a[0] = 5'd1; req_right[0] = 1'b0;
    req_valid = 2'b01;
    @(posedge clk); #1;
    req_valid = 2'b00;
    check("mid_busy_shift", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check("mid_busy_rst", 32'(busy), 32'd0);
    #2;
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      check($sformatf("mid%0d_no_rsp", k), 32'(rsp_valid), 32'd0);
    end
    run_op(1'b1, 32'hDEAD_BEEF, 5'd0, 1'b1, 1'b1, 32'hDEAD_BEEF, "sa0_p1");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
